// File: rtl/booth_mult16_if.sv
// booth_mult16_if: request/result bundle between the execute stage and the Booth multiplier
interface booth_mult16_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        result_rdy;
  logic [15:0] product;
  logic [15:0] product_hi;
  logic        overflow;
  modport master (output start, a, b, input busy, result_rdy, product, product_hi, overflow);
  modport slave  (input start, a, b, output busy, result_rdy, product, product_hi, overflow);
endinterface

// File: rtl/booth_mult16.sv
// booth_mult16: multicycle radix-2 Booth signed 16x16 multiplier; BOOTH_EARLY_TERM_EN enables early termination
module booth_mult16 #(
  parameter int WIDTH = 16
) (
  input logic           clock,
  input logic           reset,
  booth_mult16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state, state_d;
  logic [2*WIDTH-1:0]     m, acc, acc_d, term;
  logic [WIDTH-1:0]       q, q_sh, prod_lo, prod_hi;
  logic                   prev, last, ovf;
  logic [3:0]             cnt;
  // Booth step for the current iteration and end-of-run detection
  always_comb begin
    term  = m << cnt;
    acc_d = {q[cnt], prev} == 2'b10 ? acc - term :
            {q[cnt], prev} == 2'b01 ? acc + term : acc;
    q_sh  = $signed(q) >>> cnt;
`ifdef BOOTH_EARLY_TERM_EN
    last  = (&q_sh) | ~(|q_sh);
`else
    last  = cnt == 4'd15;
`endif
  end
  // Next-state logic
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  // State register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_d;
  // Operand latch, accumulator iteration and result capture
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      prev    <= 1'b0;
      cnt     <= '0;
      prod_lo <= '0;
      prod_hi <= '0;
      ovf     <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      m    <= {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
      q    <= bus.b;
      acc  <= '0;
      prev <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      acc  <= acc_d;
      prev <= q[cnt];
      cnt  <= cnt + 4'd1;
      if (last) begin
        prod_lo <= acc_d[WIDTH-1:0];
        prod_hi <= acc_d[2*WIDTH-1:WIDTH];
        ovf     <= ~((&acc_d[2*WIDTH-1:WIDTH-1]) | ~(|acc_d[2*WIDTH-1:WIDTH-1]));
      end
    end
  assign bus.busy       = state == RUN;
  assign bus.result_rdy = state == DONE;
  assign bus.product    = prod_lo;
  assign bus.product_hi = prod_hi;
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_booth_mult16.sv
// tb_booth_mult16: table-driven and sequence checks for booth_mult16
module tb_booth_mult16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  booth_mult16_if bus();
  booth_mult16 dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    logic        ov;
  } vec_t;

`ifdef BOOTH_EARLY_TERM_EN
  localparam int INJ = 2;
  localparam int RST_AT = 3;
`else
  localparam int INJ = 5;
  localparam int RST_AT = 8;
`endif

  int total = 0;
  int bad = 0;
  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
    int r;
    logic [15:0] s;
    r = 17;
`ifdef BOOTH_EARLY_TERM_EN
    for (int i = 15; i >= 0; i--) begin
      s = $signed(b) >>> i;
      if (s == 16'h0000 || s == 16'hFFFF) r = i + 2;
    end
`endif
    return r;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clock);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (bus.result_rdy) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, rdy_cnt, rdy_at, falls;
    logic prev_busy;
    logic [15:0] lo;
    vecs[0]  = '{16'd3,      16'd5,      32'h0000000F, 1'b0};
    vecs[1]  = '{16'hFFF9,   16'd6,      32'hFFFFFFD6, 1'b0};
    vecs[2]  = '{16'd300,    16'd200,    32'h0000EA60, 1'b1};
    vecs[3]  = '{16'h8000,   16'hFFFF,   32'h00008000, 1'b1};
    vecs[4]  = '{16'd1234,   16'd0,      32'h00000000, 1'b0};
    vecs[5]  = '{16'd0,      16'h8001,   32'h00000000, 1'b0};
    vecs[6]  = '{16'd5,      16'd3,      32'h0000000F, 1'b0};
    vecs[7]  = '{16'hFFFF,   16'hFFFF,   32'h00000001, 1'b0};
    vecs[8]  = '{16'h7FFF,   16'h7FFF,   32'h3FFF0001, 1'b1};
    vecs[9]  = '{16'h8000,   16'h8000,   32'h40000000, 1'b1};
    vecs[10] = '{16'd256,    16'hFF80,   32'hFFFF8000, 1'b0};
    vecs[11] = '{16'd256,    16'd128,    32'h00008000, 1'b1};
    vecs[12] = '{16'd100,    16'd100,    32'h00002710, 1'b0};
    vecs[13] = '{16'hFFFF,   16'd1,      32'hFFFFFFFF, 1'b0};
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rdy", {31'd0, bus.result_rdy}, 32'd0);
    check("rst_prod", {bus.product_hi, bus.product}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b1;
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_lat", i), lat, exp_lat(vecs[i].b));
      check($sformatf("v%0d_prod", i), {bus.product_hi, bus.product}, vecs[i].p);
      check($sformatf("v%0d_ovf", i), {31'd0, bus.overflow}, {31'd0, vecs[i].ov});
      check($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd0);
    end
    // second start during RUN must be ignored
    @(negedge clock);
    bus.a = 16'd3;
    bus.b = 16'd5;
    bus.start = 1'b1;
    prev_busy = bus.busy;
    rdy_cnt = 0;
    rdy_at = 0;
    falls = 0;
    lo = '0;
    @(posedge clock);
    #1 bus.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) check("busy_rise", {31'd0, bus.busy}, 32'd1);
      if (bus.result_rdy) begin
        rdy_cnt++;
        rdy_at = n;
        lo = bus.product;
      end
      if (prev_busy && !bus.busy) falls++;
      prev_busy = bus.busy;
      bus.start = n == INJ;
      if (n == INJ) begin
        bus.a = 16'd9;
        bus.b = 16'd9;
      end
    end
    check("ign_rdy_cnt", rdy_cnt, 1);
    check("ign_rdy_at", rdy_at, exp_lat(16'd5));
    check("ign_prod", {16'd0, lo}, 32'h0000000F);
    check("ign_falls", falls, 1);
    // reset mid-operation aborts and clears everything
    @(negedge clock);
    bus.a = 16'd100;
    bus.b = 16'd100;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    repeat (RST_AT) @(negedge clock);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_rdy", {31'd0, bus.result_rdy}, 32'd0);
    check("mid_rst_prod", {bus.product_hi, bus.product}, 32'd0);
    check("mid_rst_ovf", {31'd0, bus.overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    rdy_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (bus.result_rdy || bus.busy) rdy_cnt++;
    end
    check("post_rst_idle", rdy_cnt, 0);
    run_op(16'd2, 16'd2, lat);
    check("post_rst_lat", lat, exp_lat(16'd2));
    check("post_rst_prod", {bus.product_hi, bus.product}, 32'h00000004);
    check("post_rst_ovf", {31'd0, bus.overflow}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/booth_mult16.md
Name: booth_mult16

Overview:
- Multicycle signed 16x16 multiplier built on the left-shift datapath.
- Each iteration adds or subtracts the multiplicand shifted left by the iteration index, selected by radix-2 Booth recoding of the multiplier.
- Sits in the ALU execute stage beside the 16-bit logical-left shifter.
- Produces a 32-bit product and a 16-bit signed overflow flag for the writeback and exception logic.

Parameters:
- WIDTH, 16, operand width. Only 16 is supported. Counter width is 4 bits and product width is 2*WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  single-cycle request; sampled only while idle
- a  input  16  multiplicand, two's complement
- b  input  16  multiplier, two's complement
- busy  output  1  high while an operation is in progress
- result_rdy  output  1  one-cycle pulse when product and overflow become valid
- product  output  16  low half of the product
- product_hi  output  16  high half of the product
- overflow  output  1  full product does not fit in 16-bit signed

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy=0, result_rdy=0, product=0, product_hi=0, overflow=0.
  - Counter and internal registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a into M (sign-extended to 32 bits) and b into Q.
  - Clear accumulator ACC (32 bits), set prev=0, cnt=0.
  - Go to RUN; busy=1 from that edge.
- RUN, iteration i = cnt:
  - Booth pair (Q[i], prev): 10 -> ACC -= M<<i; 01 -> ACC += M<<i; 00 and 11 -> no change.
  - Then prev=Q[i] and cnt=cnt+1.
  - All arithmetic is mod 2^32. The shift is logical left with zero fill.
  - When i=15, go to DONE.
- DONE (one cycle):
  - product=ACC[15:0], product_hi=ACC[31:16], result_rdy=1, busy=0.
  - overflow = ACC[31:15] not all equal.
  - Next edge returns to IDLE.
- Latency: start sampled at edge E0; RUN occupies E1..E16; outputs and result_rdy are valid in the cycle following E16 (DONE).
- Output retention: product, product_hi and overflow hold their values until the next DONE or reset. result_rdy is high only in DONE.
- start while busy, or in the DONE cycle: ignored. No queuing.
- Operand changes during RUN have no effect, because operands are latched.
- Reset asserted mid-operation: the operation is aborted immediately and all outputs go to their reset values. No result_rdy is produced.
- Boundary cases:
  - a=-32768 with b=-1 gives +32768: overflow=1, product=0x8000.
  - Either operand 0 gives product 0 and overflow 0. The full 16 iterations still run.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined:
  - After iteration i, if bits Q[15:i+1] all equal Q[i], the remaining Booth terms are zero.
  - The block goes to DONE directly and skips the remaining iterations.
  - Latency becomes i+1 RUN cycles, minimum 1 (e.g. b=0 or b=-1 finishes after iteration 0).
  - Results are identical to the full run.
- Undefined: always 16 RUN cycles.

Test Plan:
- a=3, b=5, start one cycle -> result_rdy exactly 17 cycles after the start edge; product=0x000F, product_hi=0x0000, overflow=0.
- a=-7 (0xFFF9), b=6 -> product=0xFFD6, product_hi=0xFFFF, overflow=0.
- a=300, b=200 -> product=0xEA60, product_hi=0x0000, overflow=1. Also a=-32768, b=-1 -> product=0x8000, product_hi=0x0000, overflow=1.
- Start 3*5, then pulse start with a=9, b=9 at cycle 5 of RUN -> second request ignored; single result_rdy with 0x000F; busy falls once.
- Assert reset at cycle 8 of a 100*100 run -> busy, result_rdy and all outputs 0 immediately; no result_rdy after release; next start of 2*2 gives 0x0004.
- With BOOTH_EARLY_TERM_EN defined: a=1234, b=0 -> result_rdy 2 cycles after start, product=0. a=5, b=3 -> done after iteration 2, product=0x000F.
